// File: rtl/rp_axi_acq_pack.sv
// rp_axi_acq_pack: packs sign-extended ADC samples into beats under a pre/post trigger
// capture sequence and queues them in a small FIFO for the AXI write path.
module rp_axi_acq_pack #(
  parameter int DW  = 14,
  parameter int CH  = 2,
  parameter int BW  = 64,
  parameter int FAW = 2,
  parameter int CW  = 32,
  localparam int L  = BW / 16,
  localparam int SW = CH > 1 ? $clog2(CH) : 1,
  localparam int LW = L > 1 ? $clog2(L) : 1
) (
  input  logic             axi_clk_i,
  input  logic             axi_rst_i,
  input  logic [CH*DW-1:0] dat_i,
  input  logic             dv_i,
  input  logic             mode_i,
  input  logic [SW-1:0]    ch_sel_i,
  input  logic             arm_i,
  input  logic             rst_do_i,
  input  logic             trig_i,
  input  logic [CW-1:0]    pre_i,
  input  logic [CW-1:0]    dly_i,
  output logic [BW-1:0]    m_data_o,
  output logic [BW/8-1:0]  m_strb_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_trig_o,
  output logic             m_last_o,
  output logic [2:0]       state_o,
  output logic [31:0]      trig_beat_o,
  output logic [LW-1:0]    trig_lane_o,
  output logic             overflow_o,
  output logic             done_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, FLUSH = 3'd4, DONE = 3'd5} state_t;
  localparam int EW = BW + BW / 8 + 2;
  state_t state_q, state_d;
  logic [LW-1:0] ptr_q, ptr_d, tlane_q, tlane_d, nptr;
  logic [BW-1:0] lane_q, lane_d, pdat_q, pdat_d, merged;
  logic [BW/8-1:0] pstrb_q, pstrb_d, mask;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] beat_q, beat_d, tbeat_q, tbeat_d;
  logic tflag_q, tflag_d, pend_q, pend_d, ptrig_q, ptrig_d, plast_q, plast_d, ovf_q, ovf_d;
  logic [FAW:0] wp_q, wp_d, rp_q, rp_d;
  logic [EW-1:0] mem_q [2**FAW];
  logic [EW-1:0] head;
  logic [15:0] wd [CH];
  logic [LW:0] sum;
  logic cap, wrap, accept, lastsmp, empty, full, pop, push_ok;
  assign empty   = wp_q == rp_q;
  assign full    = (wp_q[FAW] != rp_q[FAW]) && (wp_q[FAW-1:0] == rp_q[FAW-1:0]);
  assign pop     = !empty && m_ready_i;
  assign push_ok = pend_q && (!full || pop);
  assign cap     = dv_i && (state_q == PRE || state_q == ARMED || state_q == POST);
  assign accept  = dv_i && trig_i && state_q == ARMED;
  assign lastsmp = (accept && dly_i == '0) || (dv_i && state_q == POST && cnt_q == CW'(1));
  always_comb begin
    for (int c = 0; c < CH; c++) wd[c] = 16'({{16{dat_i[c*DW+DW-1]}}, dat_i[c*DW +: DW]});
    merged = lane_q;
    if (mode_i) for (int c = 0; c < CH; c++) merged[((int'(ptr_q) + c) % L) * 16 +: 16] = wd[c];
    else merged[{ptr_q, 4'b0} +: 16] = wd[ch_sel_i];
    sum  = {1'b0, ptr_q} + (mode_i ? (LW+1)'(CH) : (LW+1)'(1));
    wrap = sum >= (LW+1)'(L);
    nptr = wrap ? LW'(sum - (LW+1)'(L)) : LW'(sum);
    for (int j = 0; j < L; j++) mask[2*j +: 2] = {2{LW'(j) < nptr}};
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    tbeat_d = tbeat_q;
    tlane_d = tlane_q;
    tflag_d = tflag_q;
    pend_d  = 1'b0;
    pdat_d  = pdat_q;
    pstrb_d = pstrb_q;
    ptrig_d = ptrig_q;
    plast_d = plast_q;
    wp_d    = wp_q + (FAW+1)'(push_ok);
    rp_d    = rp_q + (FAW+1)'(pop);
    ovf_d   = ovf_q | (pend_q & ~push_ok);
    if (cap) begin
      lane_d  = wrap ? '0 : merged;
      ptr_d   = nptr;
      tflag_d = (tflag_q | accept) & ~(wrap | lastsmp);
      if (wrap || lastsmp) begin
        pend_d  = 1'b1;
        pdat_d  = merged;
        pstrb_d = wrap ? '1 : mask;
        ptrig_d = tflag_q | accept;
        plast_d = lastsmp;
        beat_d  = beat_q + 32'd1;
      end
    end
    if (accept) begin
      tbeat_d = beat_q;
      tlane_d = ptr_q;
    end
    case (state_q)
      PRE: if (dv_i) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q + CW'(1) >= pre_i) state_d = ARMED;
      end
      ARMED: if (accept) begin
        cnt_d   = dly_i;
        state_d = dly_i == '0 ? FLUSH : POST;
      end
      POST: if (dv_i) begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FLUSH;
      end
      FLUSH: if (!pend_q && empty) state_d = DONE;
      default: ;
    endcase
    // soft clear outranks arm; both restart packer and FIFO
    if (arm_i || rst_do_i) begin
      state_d = rst_do_i ? IDLE : (pre_i == '0 ? ARMED : PRE);
      cnt_d   = '0;
      ptr_d   = '0;
      lane_d  = '0;
      tflag_d = 1'b0;
      pend_d  = 1'b0;
      beat_d  = '0;
      wp_d    = '0;
      rp_d    = '0;
      ovf_d   = 1'b0;
    end
  end
  always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
    if (axi_rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      tbeat_q <= '0;
      tlane_q <= '0;
      tflag_q <= 1'b0;
      pend_q  <= 1'b0;
      pdat_q  <= '0;
      pstrb_q <= '0;
      ptrig_q <= 1'b0;
      plast_q <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      tbeat_q <= tbeat_d;
      tlane_q <= tlane_d;
      tflag_q <= tflag_d;
      pend_q  <= pend_d;
      pdat_q  <= pdat_d;
      pstrb_q <= pstrb_d;
      ptrig_q <= ptrig_d;
      plast_q <= plast_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge axi_clk_i) if (push_ok) mem_q[wp_q[FAW-1:0]] <= {plast_q, ptrig_q, pstrb_q, pdat_q};
  assign head        = mem_q[rp_q[FAW-1:0]];
  assign m_valid_o   = !empty;
  assign m_data_o    = empty ? '0 : head[BW-1:0];
  assign m_strb_o    = empty ? '0 : head[BW +: BW/8];
  assign m_trig_o    = !empty && head[EW-2];
  assign m_last_o    = !empty && head[EW-1];
  assign state_o     = state_q;
  assign done_o      = state_q == DONE;
  assign trig_beat_o = tbeat_q;
  assign trig_lane_o = tlane_q;
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_rp_axi_acq_pack.sv
// tb_rp_axi_acq_pack: directed and randomized acquisitions against a word-list reference model.
module tb_rp_axi_acq_pack;
  localparam int DW = 14, CH = 2, BW = 64, FAW = 2, CW = 32;
  localparam int L = BW / 16, SW = 1, LW = 2, EW = BW + BW / 8 + 2;
  logic axi_clk_i = 0, axi_rst_i = 1;
  logic [CH*DW-1:0] dat_i = '0;
  logic dv_i = 0, mode_i = 0, arm_i = 0, rst_do_i = 0, trig_i = 0, m_ready_i = 0;
  logic [SW-1:0] ch_sel_i = '0;
  logic [CW-1:0] pre_i = '0, dly_i = '0;
  logic [BW-1:0] m_data_o;
  logic [BW/8-1:0] m_strb_o;
  logic m_valid_o, m_trig_o, m_last_o, overflow_o, done_o;
  logic [2:0] state_o;
  logic [31:0] trig_beat_o;
  logic [LW-1:0] trig_lane_o;
  rp_axi_acq_pack #(.DW(DW), .CH(CH), .BW(BW), .FAW(FAW), .CW(CW)) dut (
    .axi_clk_i(axi_clk_i), .axi_rst_i(axi_rst_i), .dat_i(dat_i), .dv_i(dv_i), .mode_i(mode_i),
    .ch_sel_i(ch_sel_i), .arm_i(arm_i), .rst_do_i(rst_do_i), .trig_i(trig_i), .pre_i(pre_i),
    .dly_i(dly_i), .m_data_o(m_data_o), .m_strb_o(m_strb_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_trig_o(m_trig_o), .m_last_o(m_last_o), .state_o(state_o),
    .trig_beat_o(trig_beat_o), .trig_lane_o(trig_lane_o), .overflow_o(overflow_o), .done_o(done_o)
  );
  always #5 axi_clk_i = ~axi_clk_i;
  int n_vec = 0, n_err = 0, rdy_mode = 2;
  logic st_dv [256];
  logic st_trig [256];
  logic [CH*DW-1:0] st_dat [256];
  logic [EW-1:0] rx_q [$];
  logic [EW-1:0] exp_q [$];
  int exp_tb, exp_tl;
  logic [EW-1:0] beat_now;
  assign beat_now = {m_last_o, m_trig_o, m_strb_o, m_data_o};
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic dv, input logic tr, input logic [CH*DW-1:0] d);
    dv_i = dv;
    trig_i = tr;
    dat_i = d;
    @(posedge axi_clk_i);
    #1;
  endtask
  initial begin
    bit ph = 0;
    forever begin
      @(posedge axi_clk_i);
      #1;
      ph = !ph;
      m_ready_i = rdy_mode == 2 ? 1'b1 : rdy_mode == 1 ? 1'b0 : (ph | 1'($urandom_range(0, 1)));
    end
  end
  initial begin
    logic hold_p = 0, ctl_p = 1;
    logic [EW-1:0] beat_p = '0;
    forever begin
      @(negedge axi_clk_i);
      if (hold_p && !ctl_p) begin
        check("hold.valid", m_valid_o, 1);
        check("hold.beat", beat_now, beat_p);
      end
      if (m_valid_o && m_ready_i) rx_q.push_back(beat_now);
      hold_p = m_valid_o && !m_ready_i;
      ctl_p = arm_i | rst_do_i | axi_rst_i;
      beat_p = beat_now;
    end
  end
  function automatic logic [15:0] sext(input logic [CH*DW-1:0] d, input int ch);
    int v;
    v = int'((d >> (ch * DW)) & ((1 << DW) - 1));
    if (v >= (1 << (DW - 1))) v -= (1 << DW);
    return v[15:0];
  endfunction
  task automatic model(input int n, input bit md, input int sel, input int pre, input int dly);
    logic [15:0] words [$];
    logic [BW-1:0] d;
    logic [BW/8-1:0] s;
    int k = 0, t = 0, lastk = 0, w, nb;
    w = md ? CH : 1;
    exp_q.delete();
    for (int c = 0; c < n; c++) if (st_dv[c] && (lastk == 0 || k < lastk)) begin
      k++;
      if (t == 0 && k > pre && st_trig[c]) begin
        t = k;
        lastk = k + dly;
      end
      for (int ch = 0; ch < w; ch++) words.push_back(sext(st_dat[c], md ? ch : sel));
    end
    exp_tb = (t - 1) * w / L;
    exp_tl = (t - 1) * w % L;
    nb = (words.size() + L - 1) / L;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      s = '0;
      for (int j = 0; j < L; j++) if (b * L + j < words.size()) begin
        d[16*j +: 16] = words[b*L+j];
        s[2*j +: 2] = 2'b11;
      end
      exp_q.push_back({1'(b == nb - 1), 1'(b == exp_tb), s, d});
    end
  endtask
  task automatic run(input int n, input bit md, input int sel, input int pre, input int dly, input string tag);
    logic [EW-1:0] g, e;
    logic [BW-1:0] bm;
    int w = 0;
    mode_i = md;
    ch_sel_i = SW'(sel);
    pre_i = CW'(pre);
    dly_i = CW'(dly);
    arm_i = 1;
    cyc(0, 0, '0);
    arm_i = 0;
    rx_q.delete();
    for (int c = 0; c < n; c++) cyc(st_dv[c], st_trig[c], st_dat[c]);
    while (!done_o && w < 200) begin
      cyc(0, 0, '0);
      w++;
    end
    check({tag, ".done"}, done_o, 1);
    check({tag, ".state"}, state_o, 5);
    check({tag, ".ovf"}, overflow_o, 0);
    model(n, md, sel, pre, dly);
    check({tag, ".nbeats"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      g = rx_q[i];
      e = exp_q[i];
      bm = '0;
      for (int j = 0; j < BW / 8; j++) if (e[BW+j]) bm[8*j +: 8] = 8'hff;
      check($sformatf("%s.data%0d", tag, i), g[BW-1:0] & bm, e[BW-1:0] & bm);
      check($sformatf("%s.ctl%0d", tag, i), g[EW-1:BW], e[EW-1:BW]);
    end
    check({tag, ".tbeat"}, trig_beat_o, exp_tb);
    check({tag, ".tlane"}, trig_lane_o, exp_tl);
  endtask
  initial begin
    logic [EW-1:0] g;
    #200000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [EW-1:0] g;
    repeat (3) @(posedge axi_clk_i);
    #1;
    check("rst.state", state_o, 0);
    check("rst.outs", {m_valid_o, m_trig_o, m_last_o, done_o, overflow_o, m_strb_o}, 0);
    check("rst.data", m_data_o, 0);
    check("rst.trig", {trig_beat_o, trig_lane_o}, 0);
    axi_rst_i = 0;
    cyc(0, 0, '0);
    for (int k = 1; k <= 9; k++) begin
      st_dv[k-1] = 1;
      st_trig[k-1] = k == 2 || k == 6;
      st_dat[k-1] = {14'($urandom), 14'(k)};
    end
    run(9, 0, 0, 4, 3, "single");
    if (rx_q.size() >= 3) begin
      g = rx_q[0];
      check("single.b0", g[BW-1:0], {16'd4, 16'd3, 16'd2, 16'd1});
      g = rx_q[1];
      check("single.b1trig", g[EW-2], 1);
      g = rx_q[2];
      check("single.b2", {g[EW-1], g[BW +: 8], g[15:0]}, {1'b1, 8'h03, 16'd9});
    end
    check("single.tbeat_k", trig_beat_o, 1);
    check("single.tlane_k", trig_lane_o, 1);
    for (int k = 1; k <= 4; k++) begin
      st_dv[k-1] = 1;
      st_trig[k-1] = k == 4;
      st_dat[k-1] = {14'(100 + k), k == 1 ? 14'h2000 : 14'(k)};
    end
    run(4, 1, 0, 0, 0, "ilv");
    if (rx_q.size() >= 2) begin
      g = rx_q[0];
      check("ilv.sext", g[15:0], 16'hE000);
      check("ilv.b0trig", g[EW-2], 0);
      g = rx_q[1];
      check("ilv.b1", {g[EW-1:BW], g[BW-1:0]}, {1'b1, 1'b1, 8'hff, 16'd104, 16'd4, 16'd103, 16'd3});
    end
    check("ilv.tlane_k", trig_lane_o, 2);
    rdy_mode = 1;
    mode_i = 0;
    ch_sel_i = '0;
    pre_i = '0;
    dly_i = 100;
    arm_i = 1;
    cyc(0, 0, '0);
    arm_i = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1, k == 1, {14'd0, 14'(k)});
      if (k == 4) check("lat.pre", m_valid_o, 0);
      if (k == 5) check("lat.valid", m_valid_o, 1);
    end
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    check("ovf.set", overflow_o, 1);
    rx_q.delete();
    rdy_mode = 2;
    repeat (10) cyc(0, 0, '0);
    check("ovf.kept", rx_q.size(), 4);
    if (rx_q.size() >= 4) begin
      g = rx_q[0];
      check("ovf.first", g[15:0], 1);
      g = rx_q[3];
      check("ovf.fourth", g[63:48], 16);
    end
    check("ovf.drained", m_valid_o, 0);
    check("ovf.post", state_o, 3);
    rdy_mode = 1;
    for (int k = 21; k <= 28; k++) cyc(1, 0, {14'd0, 14'(k)});
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    check("sclr.queued", m_valid_o, 1);
    check("sclr.ovf_pre", overflow_o, 1);
    rst_do_i = 1;
    cyc(0, 0, '0);
    rst_do_i = 0;
    check("sclr.state", state_o, 0);
    check("sclr.valid", m_valid_o, 0);
    check("sclr.ovf", overflow_o, 0);
    rdy_mode = 0;
    pre_i = 3;
    arm_i = 1;
    rst_do_i = 1;
    cyc(0, 0, '0);
    arm_i = 0;
    rst_do_i = 0;
    check("armclr.state", state_o, 0);
    pre_i = '0;
    arm_i = 1;
    cyc(0, 0, '0);
    arm_i = 0;
    check("arm0.state", state_o, 2);
    for (int r = 0; r < 24; r++) begin
      int pre, dly, t, n, k;
      bit md;
      pre = $urandom_range(0, 5);
      dly = $urandom_range(0, 9);
      t = pre + $urandom_range(1, 6);
      md = 1'($urandom_range(0, 1));
      n = 0;
      k = 0;
      while (k < t + dly + 3 && n < 250) begin
        st_dv[n] = $urandom_range(0, 9) < 7;
        if (st_dv[n]) k++;
        st_trig[n] = !st_dv[n] || k <= pre || k > t ? 1'($urandom_range(0, 1)) : k == t;
        st_dat[n] = CH*DW'($urandom);
        n++;
      end
      run(n, md, $urandom_range(0, CH - 1), pre, dly, $sformatf("rnd%0d", r));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rp_axi_acq_pack.md
# rp_axi_acq_pack

Parametrised multi-channel acquisition packer and trigger state machine. It sign-extends ADC samples to 16-bit words and packs them into BW-bit beats. It runs an explicit pre-trigger / post-trigger capture sequence and buffers beats in a small FIFO. The output is a valid/ready beat stream for the AXI write FIFO, plus the trigger position within the stream. It sits between the ADC front end and the AXI write master of each acquisition path.

## Interface
- DW, 14, ADC sample width (≤16).
- CH, 2, channel count (power of 2).
- BW, 64, beat width. L = BW/16 lanes; L is a multiple of CH.
- FAW, 2, FIFO address width (depth 2^FAW).
- CW, 32, pre/post counter width.

Ports:
- axi_clk_i  in  1  clock.
- axi_rst_i  in  1  reset, asynchronous, active-high.
- dat_i  in  CH*DW  channel c at [c*DW +: DW].
- dv_i  in  1  sample instant valid.
- mode_i  in  1  0 = single channel (ch_sel_i), 1 = all channels interleaved.
- ch_sel_i  in  $clog2(CH) (min 1)  channel used in single mode.
- arm_i  in  1  start acquisition.
- rst_do_i  in  1  soft clear.
- trig_i  in  1  trigger, qualified by dv_i.
- pre_i  in  CW  minimum sample instants before a trigger is accepted.
- dly_i  in  CW  sample instants captured after the trigger sample.
- m_data_o  out  BW  beat data, lane 0 at [15:0].
- m_strb_o  out  BW/8  byte strobes.
- m_valid_o  out  1  beat valid.
- m_ready_i  in  1  downstream ready.
- m_trig_o  out  1  beat contains the trigger sample.
- m_last_o  out  1  final beat of the acquisition.
- state_o  out  3  FSM state.
- trig_beat_o  out  32  index of the trigger beat since arm.
- trig_lane_o  out  $clog2(L)  lane of the trigger sample's first word.
- overflow_o  out  1  sticky beat-drop flag.
- done_o  out  1  acquisition complete.

## Operation
- Words per sample instant: W = 1 (single mode) or CH (interleaved mode). Each word is the channel's DW sample sign-extended to 16 bits.
- In interleaved mode, channels 0..CH-1 go into consecutive lanes.
- Capture is active in PRE, ARMED and POST. Each dv_i writes W words at the lane pointer, then the pointer advances by W mod L.
- When the pointer wraps, the beat is complete and is pushed with strb all-ones.
- FSM state encodings:
  - IDLE = 0.
  - PRE = 1.
  - ARMED = 2.
  - POST = 3.
  - FLUSH = 4.
  - DONE = 5.
- FSM transitions:
  - IDLE: arm_i → PRE, or → ARMED when pre_i = 0. Arming clears the lane pointer, beat counter, FIFO and overflow_o.
  - PRE: the pre counter counts dv_i. When the count reaches pre_i → ARMED. trig_i is ignored in PRE.
  - ARMED: trig_i && dv_i marks that sample as the trigger sample.
    - trig_beat_o is latched to the current beat counter; trig_lane_o is latched to the lane pointer.
    - The FSM then goes → POST with the counter loaded from dly_i, or → FLUSH when dly_i = 0.
  - POST: each dv_i decrements the counter. The dv_i that takes the counter from 1 to 0 is the last sample → FLUSH.
  - FLUSH: the final sample's beat gets m_last_o.
    - If that beat is full, it is pushed with last on completion.
    - Otherwise FLUSH pushes the partial beat with strb covering only the filled lanes.
    - The FSM then waits for the FIFO to empty → DONE.
  - DONE: done_o = 1. arm_i → PRE (or ARMED).
- arm_i in any state restarts the sequence as from IDLE.
- rst_do_i in any state → IDLE next cycle and flushes FIFO and packer. rst_do_i has priority over arm_i and trig_i.
- A beat pushed while the FIFO is full is dropped and sets overflow_o. overflow_o is cleared only by arm_i, rst_do_i or reset.
- The beat counter is 32-bit, increments on each push attempt, and wraps.
- m_trig_o accompanies the beat holding the trigger sample.

## Timing
- On reset:
  - All outputs are 0.
  - state_o = IDLE.
  - FIFO is empty.
- The lanes of a beat register at the clock edge ending the dv_i cycle. The push happens one cycle later.
- m_valid_o rises 2 cycles after the completing dv_i when the FIFO was empty.
- Valid/ready handshake:
  - A transfer occurs when m_valid_o && m_ready_i.
  - Data, strb, trig and last stay stable while valid is high and ready is low.
  - Valid is never withdrawn without a transfer, except on rst_do_i or arm_i.
- A simultaneous push and pop on a full FIFO succeeds (no drop).
- The state change occurs at the clock edge of the qualifying event. state_o reflects the new state one cycle after that event.
- A partial flush is pushed the cycle after entry to FLUSH.

## Test plan
- Single mode, ch 0, L = 4, pre = 4, dly = 3, dv_i every cycle, samples 1..9, trig on sample 2 and on sample 6:
  - Trigger on sample 2 is ignored; trigger on sample 6 is accepted.
  - Beats {1,2,3,4} and {5,6,7,8} (trig), then {9} with strb 0x03 and last.
  - trig_beat_o = 1, trig_lane_o = 1, done_o = 1.
- Interleaved mode, CH = 2, 4 instants (a_i, b_i), dly = 0 trigger on instant 4:
  - Beats {a1,b1,a2,b2} and {a3,b3,a4,b4}; the second beat has trig and last and is not partial.
- DW = 14, input 14'h2000 → lane value 16'hE000.
- m_ready_i held low, FAW = 2, 5 full beats → 4 beats retained, overflow_o = 1, 5th beat dropped.
- rst_do_i asserted mid-POST with 2 beats queued → state_o = 0 next cycle, m_valid_o = 0, overflow_o = 0.
- arm_i and rst_do_i in the same cycle → IDLE. A following arm_i with pre_i = 0 → state_o = 2.
